nor_logic_unit: RTL and testbench

//  Parametrised, pipelined 2-input bitwise logic unit. Every function is built only from 2-input NOR cells.
//  It succeeds the single-bit combinational NOR-built gates. It adds width, op select, a 2-stage pipeline,
//  a valid/ready handshake and a transaction counter. It sits between an operand source and any

---
 rtl/nor_lu_pkg.sv | 15 +
 rtl/nor_logic_unit_if.sv | 28 ++
 rtl/nor2_cell.sv | 12 +
 rtl/nor_logic_unit.sv | 125 ++++++++++++
 tb/tb_nor_logic_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/nor_lu_pkg.sv
// Shared constants for the NOR-built logic unit: op-select encoding and width.
package nor_lu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

// File: rtl/nor_logic_unit_if.sv
// Operand/result handshake bundle between an operand source (master) and the logic unit (slave).
interface nor_logic_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import nor_lu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] txn_cnt;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, txn_cnt
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, txn_cnt
  );

endinterface

// File: rtl/nor2_cell.sv
// Bitwise 2-input NOR; the only logic primitive used by the unit's datapath.
module nor2_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a | b);

endmodule

// File: rtl/nor_logic_unit.sv
// Two-stage pipelined bitwise logic unit built only from NOR cells, with
// valid/ready flow control on both sides and a consumed-result counter.
module nor_logic_unit
  import nor_lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  nor_logic_unit_if.slave   bus
);

  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [OP_W-1:0]  op1;
  logic [WIDTH-1:0] na1;
  logic [WIDTH-1:0] nb1;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] cnt_q;

  logic             rdy2;
  logic             load1;
  logic             load2;
  logic             drain;

  logic [WIDTH-1:0] na_d;
  logic [WIDTH-1:0] nb_d;
  logic [WIDTH-1:0] n_d;

  logic [WIDTH-1:0] and_t;
  logic [WIDTH-1:0] or_t;
  logic [WIDTH-1:0] nand_t;
  logic [WIDTH-1:0] xa_t;
  logic [WIDTH-1:0] xb_t;
  logic [WIDTH-1:0] xnor_t;
  logic [WIDTH-1:0] xor_t;
  logic [WIDTH-1:0] pass_t;
  logic [WIDTH-1:0] result;

  // A stage may refill in the same cycle it hands its contents downstream.
  assign rdy2         = !v2 || bus.out_ready;
  assign bus.in_ready = !v1 || rdy2;
  assign load1        = bus.in_valid && bus.in_ready;
  assign load2        = v1 && rdy2;
  assign drain        = v2 && bus.out_ready;

  assign bus.out_valid = v2;
  assign bus.y         = y_q;
  assign bus.txn_cnt   = cnt_q;

  nor2_cell #(.WIDTH(WIDTH)) u_na (.a(bus.a), .b(bus.a), .y(na_d));
  nor2_cell #(.WIDTH(WIDTH)) u_nb (.a(bus.b), .b(bus.b), .y(nb_d));
  nor2_cell #(.WIDTH(WIDTH)) u_n  (.a(bus.a), .b(bus.b), .y(n_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
      na1 <= '0;
      nb1 <= '0;
      n1  <= '0;
    end else if (load1) begin
      v1  <= 1'b1;
      a1  <= bus.a;
      b1  <= bus.b;
      op1 <= bus.op;
      na1 <= na_d;
      nb1 <= nb_d;
      n1  <= n_d;
    end else if (load2) begin
      v1  <= 1'b0;
    end
  end

  nor2_cell #(.WIDTH(WIDTH)) u_and  (.a(na1),    .b(nb1),    .y(and_t));
  nor2_cell #(.WIDTH(WIDTH)) u_or   (.a(n1),     .b(n1),     .y(or_t));
  nor2_cell #(.WIDTH(WIDTH)) u_nand (.a(and_t),  .b(and_t),  .y(nand_t));
  nor2_cell #(.WIDTH(WIDTH)) u_xa   (.a(a1),     .b(n1),     .y(xa_t));
  nor2_cell #(.WIDTH(WIDTH)) u_xb   (.a(b1),     .b(n1),     .y(xb_t));
  nor2_cell #(.WIDTH(WIDTH)) u_xnor (.a(xa_t),   .b(xb_t),   .y(xnor_t));
  nor2_cell #(.WIDTH(WIDTH)) u_xor  (.a(xnor_t), .b(xnor_t), .y(xor_t));
  nor2_cell #(.WIDTH(WIDTH)) u_pass (.a(na1),    .b(na1),    .y(pass_t));

  always_comb begin
    result = pass_t;
    case (op1)
      OP_AND:    result = and_t;
      OP_OR:     result = or_t;
      OP_NAND:   result = nand_t;
      OP_NOR:    result = n1;
      OP_XOR:    result = xor_t;
      OP_XNOR:   result = xnor_t;
      OP_NOT_A:  result = na1;
      OP_PASS_A: result = pass_t;
      default:   result = pass_t;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      y_q <= '0;
    end else if (load2) begin
      v2  <= 1'b1;
      y_q <= result;
    end else if (drain) begin
      v2  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nor_logic_unit.sv
// Bench for nor_logic_unit: occupancy-level reference model checked every cycle,
// plus directed reset, backpressure, wrap and 1-bit truth-table scenarios.
module tb_nor_logic_unit;
  import nor_lu_pkg::*;

  typedef struct {
    logic [7:0] res;
    int         age;
  } item_t;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  item_t      q[$];
  logic [7:0] delivered[$];
  logic [15:0] m_cnt = 16'd0;

  nor_logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus ();
  nor_logic_unit_if #(.WIDTH(8), .CNT_W(4))  bw  ();
  nor_logic_unit_if #(.WIDTH(1), .CNT_W(16)) b1  ();

  nor_logic_unit #(.WIDTH(8), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  nor_logic_unit #(.WIDTH(8), .CNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(bw));
  nor_logic_unit #(.WIDTH(1), .CNT_W(16)) dut_1 (.clk(clk), .rst(rst), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] z, input logic [2:0] f);
    case (f)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return ~(x & z);
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                                input logic [2:0] opv, input logic orv);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.op        = opv;
    bus.out_ready = orv;
  endtask

  // Reference model: results queue in acceptance order; the oldest is visible
  // once it has spent one edge inside, and two in flight means the unit is full.
  always begin : compare
    logic exp_ir, exp_ov, do_pop, do_push;
    logic [7:0] new_res;
    @(negedge clk);
    #4;
    if (rst) begin
      q.delete();
      m_cnt = 16'd0;
      check_output("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_output("rst y", {24'd0, bus.y}, 32'd0);
      check_output("rst txn_cnt", {16'd0, bus.txn_cnt}, 32'd0);
      check_output("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      exp_ir = !(q.size() == 2 && !bus.out_ready);
      exp_ov = (q.size() >= 2) || (q.size() == 1 && q[0].age >= 1);
      check_output("model in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ir});
      check_output("model out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (exp_ov)
        check_output("model y", {24'd0, bus.y}, {24'd0, q[0].res});
      check_output("model txn_cnt", {16'd0, bus.txn_cnt}, {16'd0, m_cnt});
      do_pop  = exp_ov && bus.out_ready;
      do_push = bus.in_valid && exp_ir;
      new_res = ref_op(bus.a, bus.b, bus.op);
      if (do_pop)
        delivered.push_back(bus.y);
      @(posedge clk);
      if (!rst) begin
        if (do_pop) begin
          void'(q.pop_front());
          m_cnt++;
        end
        foreach (q[i]) q[i].age++;
        if (do_push)
          q.push_back('{res: new_res, age: 0});
      end
    end
  end

  logic [7:0] exp2 [8];
  logic [7:0] exp3 [3];

  initial begin : stimulus
    int n;
    logic [7:0] e1;
    exp2 = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hC3};
    exp3 = '{8'h81, 8'hE7, 8'h7E};

    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.op = 3'd0; bus.out_ready = 1'b1;
    bw.in_valid = 1'b0;  bw.a = 8'h00;  bw.b = 8'h00;  bw.op = 3'd0;  bw.out_ready = 1'b1;
    b1.in_valid = 1'b0;  b1.a = 1'b0;   b1.b = 1'b0;   b1.op = 3'd0;  b1.out_ready = 1'b1;

    // Reset held three cycles with operands offered
    repeat (3) @(negedge clk);
    #1;
    check_output("t1 out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("t1 y", {24'd0, bus.y}, 32'd0);
    check_output("t1 txn_cnt", {16'd0, bus.txn_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_output("t1 in_ready after release", {31'd0, bus.in_ready}, 32'd1);

    // Every op on C3/A5, one per cycle
    delivered.delete();
    for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 8'hC3, 8'hA5, 3'(k), 1'b1);
    repeat (3) apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check_output("t2 count", delivered.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < delivered.size()) check_output("t2 y literal", {24'd0, delivered[k]}, {24'd0, exp2[k]});
    #1;
    check_output("t2 txn_cnt", {16'd0, bus.txn_cnt}, 32'd8);

    // Backpressure: third op must wait while both stages hold
    delivered.delete();
    apply_stimulus(1'b1, 8'hC3, 8'hA5, OP_AND, 1'b0);
    apply_stimulus(1'b1, 8'hC3, 8'hA5, OP_OR, 1'b0);
    apply_stimulus(1'b1, 8'hC3, 8'hA5, OP_NAND, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
      bus.op = OP_XOR;
      check_output("t3 in_ready stalled", {31'd0, bus.in_ready}, 32'd0);
      check_output("t3 out_valid held", {31'd0, bus.out_valid}, 32'd1);
      check_output("t3 y held", {24'd0, bus.y}, 32'h81);
    end
    apply_stimulus(1'b1, 8'hC3, 8'hA5, OP_NAND, 1'b1);
    repeat (4) apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check_output("t3 count", delivered.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < delivered.size()) check_output("t3 y order", {24'd0, delivered[k]}, {24'd0, exp3[k]});

    // Streaming with random operands
    delivered.delete();
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)), 1'b1);
      #1;
      check_output("t4 in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    repeat (3) apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check_output("t4 count", delivered.size(), 32'd100);

    // Reset asserted between edges with two results in flight
    delivered.delete();
    apply_stimulus(1'b1, 8'h5A, 8'h0F, OP_XOR, 1'b0);
    apply_stimulus(1'b1, 8'h5A, 8'h0F, OP_OR, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("t5 out_valid drops", {31'd0, bus.out_valid}, 32'd0);
    check_output("t5 y cleared", {24'd0, bus.y}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("t5 in_ready after release", {31'd0, bus.in_ready}, 32'd1);
    repeat (4) apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check_output("t5 no stale result", delivered.size(), 32'd0);

    // Counter wrap on a 4-bit instance
    bw.a = 8'h0F; bw.b = 8'hF0; bw.op = OP_OR; bw.out_ready = 1'b1;
    @(negedge clk);
    bw.in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 17; c++) begin
      @(negedge clk);
      #4;
      if (bw.out_valid && bw.out_ready) begin
        n++;
        @(posedge clk);
        #1;
        if (n == 15) check_output("t6 cnt at 15", {28'd0, bw.txn_cnt}, 32'd15);
        if (n == 16) check_output("t6 cnt wraps to 0", {28'd0, bw.txn_cnt}, 32'd0);
        if (n == 17) check_output("t6 cnt then 1", {28'd0, bw.txn_cnt}, 32'd1);
      end
    end
    bw.in_valid = 1'b0;
    check_output("t6 transaction budget", n, 32'd17);

    // 1-bit instance, exhaustive operands and ops
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int f = 0; f < 8; f++) begin
          @(negedge clk);
          b1.in_valid = 1'b1; b1.a = 1'(av); b1.b = 1'(bv); b1.op = 3'(f);
          @(negedge clk);
          b1.in_valid = 1'b0;
          @(negedge clk);
          #1;
          e1 = ref_op(8'(av), 8'(bv), 3'(f));
          check_output("w1 out_valid", {31'd0, b1.out_valid}, 32'd1);
          check_output("w1 y", {31'd0, b1.y}, {31'd0, e1[0]});
        end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
